// File: rtl/axist_mgmt_test_seq.sv
// AVMM master that replays the AXI-Stream dual AIB bring-up and loopback self-check
// on the management port, and reports one sticky pass/fail result.
module axist_mgmt_test_seq #(
  parameter logic [31:0] DLY_X        = 32'h0000_000C,
  parameter logic [31:0] DLY_Y        = 32'h0000_0020,
  parameter logic [31:0] DLY_Z        = 32'h0000_1770,
  parameter logic [31:0] PKT_CTRL     = 32'h0000_0FF5,
  parameter int unsigned AXI_RST_HOLD = 100,
  parameter int unsigned POLL_GAP     = 20,
  parameter int unsigned TIMEOUT      = 200000
) (
  input  logic        mgmt_clk,
  input  logic        mgmt_rst,
  input  logic        i_start,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wrdata,
  output logic        o_wren,
  output logic        o_rden,
  input  logic        i_master_waitreq,
  input  logic        i_master_readdatavalid,
  input  logic [31:0] i_master_readdata,
  output logic        o_busy,
  output logic        o_test_done,
  output logic        o_test_pass,
  output logic [2:0]  o_l2f_sts,
  output logic [2:0]  o_f2l_sts,
  output logic [3:0]  o_err_code
);

  localparam logic [4:0] ST_IDLE         = 5'd0;
  localparam logic [4:0] ST_WR_DX        = 5'd1;
  localparam logic [4:0] ST_WR_DY        = 5'd2;
  localparam logic [4:0] ST_WR_DZ        = 5'd3;
  localparam logic [4:0] ST_AXI_RST_SET  = 5'd4;
  localparam logic [4:0] ST_AXI_RST_HOLD = 5'd5;
  localparam logic [4:0] ST_AXI_RST_CLR  = 5'd6;
  localparam logic [4:0] ST_POLL_LINK    = 5'd7;
  localparam logic [4:0] ST_START_L2F    = 5'd8;
  localparam logic [4:0] ST_START_F2L    = 5'd9;
  localparam logic [4:0] ST_POLL_L2F     = 5'd10;
  localparam logic [4:0] ST_POLL_F2L     = 5'd11;
  localparam logic [4:0] ST_RD_DOUT      = 5'd12;
  localparam logic [4:0] ST_RD_DIN       = 5'd13;
  localparam logic [4:0] ST_REPORT       = 5'd14;
  localparam logic [4:0] ST_DONE         = 5'd15;
  localparam logic [4:0] ST_ERR          = 5'd16;

  localparam logic [1:0] PH_ISSUE = 2'd0;
  localparam logic [1:0] PH_ACC   = 2'd1;
  localparam logic [1:0] PH_DATA  = 2'd2;
  localparam logic [1:0] PH_GAP   = 2'd3;

  localparam logic [31:0] HOLD_LAST = 32'(AXI_RST_HOLD - 1);
  localparam logic [31:0] GAP_LAST  = 32'(POLL_GAP - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);

  logic [4:0]   state_r;
  logic [1:0]   phase_r;
  logic [31:0]  cnt_r;
  logic [31:0]  tmo_r;
  logic [2:0]   word_r;
  logic [255:0] dout_r;
  logic [255:0] din_r;

  logic         xfer_s;
  logic         rd_s;
  logic         poll_s;
  logic [31:0]  addr_s;
  logic [31:0]  data_s;
  logic         rd_done_s;
  logic         adv_s;
  logic         timed_s;
  logic         tmo_hit_s;

  assign rd_done_s = (phase_r == PH_DATA) && i_master_readdatavalid;
  assign timed_s   = (state_r != ST_IDLE) && (state_r != ST_DONE) && (state_r != ST_ERR);
  assign tmo_hit_s = timed_s && (tmo_r >= TMO_LAST);

  // Bus transaction owned by the current state: address, write data, direction.
  always_comb begin
    xfer_s = 1'b0;
    rd_s   = 1'b0;
    poll_s = 1'b0;
    addr_s = 32'h0000_0000;
    data_s = 32'h0000_0000;
    case (state_r)
      ST_WR_DX:       begin xfer_s = 1'b1; addr_s = 32'h5000_2000; data_s = DLY_X; end
      ST_WR_DY:       begin xfer_s = 1'b1; addr_s = 32'h5000_2004; data_s = DLY_Y; end
      ST_WR_DZ:       begin xfer_s = 1'b1; addr_s = 32'h5000_2008; data_s = DLY_Z; end
      ST_AXI_RST_SET: begin xfer_s = 1'b1; addr_s = 32'h5000_3000; data_s = 32'h0000_0001; end
      ST_AXI_RST_CLR: begin xfer_s = 1'b1; addr_s = 32'h5000_3000; data_s = 32'h0000_0000; end
      ST_START_L2F:   begin xfer_s = 1'b1; addr_s = 32'h5000_1000; data_s = PKT_CTRL; end
      ST_START_F2L:   begin xfer_s = 1'b1; addr_s = 32'h5000_1008; data_s = PKT_CTRL; end
      ST_POLL_LINK:   begin xfer_s = 1'b1; rd_s = 1'b1; poll_s = 1'b1; addr_s = 32'h5000_1010; end
      ST_POLL_L2F:    begin xfer_s = 1'b1; rd_s = 1'b1; poll_s = 1'b1; addr_s = 32'h5000_1004; end
      ST_POLL_F2L:    begin xfer_s = 1'b1; rd_s = 1'b1; poll_s = 1'b1; addr_s = 32'h5000_100C; end
      ST_RD_DOUT:     begin xfer_s = 1'b1; rd_s = 1'b1; addr_s = 32'h5000_4100 + {27'd0, word_r, 2'b00}; end
      ST_RD_DIN:      begin xfer_s = 1'b1; rd_s = 1'b1; addr_s = 32'h5000_4300 + {27'd0, word_r, 2'b00}; end
      default:        begin xfer_s = 1'b0; end
    endcase
  end

  // Decides when the current state has finished and the sequence steps to the next one.
  always_comb begin
    adv_s = 1'b0;
    case (state_r)
      ST_AXI_RST_HOLD:          adv_s = (cnt_r == HOLD_LAST);
      ST_POLL_LINK:             adv_s = rd_done_s && (i_master_readdata[3:0] == 4'hF);
      ST_POLL_L2F, ST_POLL_F2L: adv_s = rd_done_s && i_master_readdata[3];
      ST_RD_DOUT, ST_RD_DIN:    adv_s = rd_done_s && (word_r == 3'd7);
      default:                  adv_s = xfer_s && !rd_s && (phase_r == PH_ACC) && !i_master_waitreq;
    endcase
  end

  // Sequencer state, AVMM request registers, capture buffers and result flags.
  always_ff @(posedge mgmt_clk) begin
    if (mgmt_rst) begin
      state_r     <= ST_IDLE;
      phase_r     <= PH_ISSUE;
      cnt_r       <= 32'd0;
      tmo_r       <= 32'd0;
      word_r      <= 3'd0;
      dout_r      <= 256'd0;
      din_r       <= 256'd0;
      o_wr_addr   <= 32'd0;
      o_wrdata    <= 32'd0;
      o_wren      <= 1'b0;
      o_rden      <= 1'b0;
      o_busy      <= 1'b0;
      o_test_done <= 1'b0;
      o_test_pass <= 1'b0;
      o_l2f_sts   <= 3'd0;
      o_f2l_sts   <= 3'd0;
      o_err_code  <= 4'd0;
    end else if (tmo_hit_s) begin
      state_r     <= ST_ERR;
      phase_r     <= PH_ISSUE;
      tmo_r       <= 32'd0;
      o_wren      <= 1'b0;
      o_rden      <= 1'b0;
      o_busy      <= 1'b0;
      o_test_done <= 1'b1;
      o_test_pass <= 1'b0;
      o_err_code  <= state_r[3:0];
    end else begin
      tmo_r <= tmo_r + 32'd1;
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            state_r <= ST_WR_DX;
            phase_r <= PH_ISSUE;
            tmo_r   <= 32'd0;
            o_busy  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_AXI_RST_HOLD: cnt_r <= cnt_r + 32'd1;
        ST_REPORT: begin
          state_r     <= ST_DONE;
          tmo_r       <= 32'd0;
          o_busy      <= 1'b0;
          o_test_done <= 1'b1;
          o_test_pass <= (o_l2f_sts == 3'b111) && (o_f2l_sts == 3'b111) && (dout_r == din_r);
        end
        ST_DONE, ST_ERR: begin
          state_r <= state_r;
        end
        default: begin
          case (phase_r)
            PH_ISSUE: begin
              o_wr_addr <= addr_s;
              o_wrdata  <= data_s;
              o_wren    <= ~rd_s;
              o_rden    <= rd_s;
              phase_r   <= PH_ACC;
            end
            PH_ACC: begin
              if (!i_master_waitreq) begin
                o_wren  <= 1'b0;
                o_rden  <= 1'b0;
                phase_r <= rd_s ? PH_DATA : PH_ACC;
              end else begin
                phase_r <= PH_ACC;
              end
            end
            PH_DATA: begin
              if (i_master_readdatavalid) begin
                case (state_r)
                  ST_POLL_L2F: o_l2f_sts <= {i_master_readdata[3], i_master_readdata[1:0]};
                  ST_POLL_F2L: o_f2l_sts <= {i_master_readdata[3], i_master_readdata[1:0]};
                  ST_RD_DOUT:  dout_r <= {i_master_readdata, dout_r[255:32]};
                  ST_RD_DIN:   din_r  <= {i_master_readdata, din_r[255:32]};
                  default:     dout_r <= dout_r;
                endcase
                word_r  <= word_r + 3'd1;
                cnt_r   <= 32'd0;
                phase_r <= poll_s ? PH_GAP : PH_ISSUE;
              end else begin
                phase_r <= PH_DATA;
              end
            end
            PH_GAP: begin
              if (cnt_r == GAP_LAST) begin
                cnt_r   <= 32'd0;
                phase_r <= PH_ISSUE;
              end else begin
                cnt_r <= cnt_r + 32'd1;
              end
            end
            default: phase_r <= PH_ISSUE;
          endcase
        end
      endcase
      // Placed last so that stepping to the next state overrides the per-state updates.
      if (adv_s) begin
        state_r <= state_r + 5'd1;
        phase_r <= PH_ISSUE;
        cnt_r   <= 32'd0;
        word_r  <= 3'd0;
        tmo_r   <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_axist_mgmt_test_seq.sv
// Randomized bench for axist_mgmt_test_seq: an AVMM responder model with configurable
// stalls and read latency, and a result model computed directly from the responder data.
module tb_axist_mgmt_test_seq;

  localparam int unsigned HOLD = 100;
  localparam int unsigned GAP  = 20;
  localparam int unsigned TMO  = 500;
  localparam logic [31:0] LINK_ADDR = 32'h5000_1010;

  logic        mgmt_clk = 1'b0;
  logic        mgmt_rst = 1'b1;
  logic        i_start  = 1'b0;
  logic        waitreq  = 1'b0;
  logic        rvalid   = 1'b0;
  logic [31:0] rdata    = 32'd0;
  logic [31:0] o_wr_addr, o_wrdata;
  logic        o_wren, o_rden, o_busy, o_test_done, o_test_pass;
  logic [2:0]  o_l2f_sts, o_f2l_sts;
  logic [3:0]  o_err_code;

  axist_mgmt_test_seq #(
    .AXI_RST_HOLD(HOLD),
    .POLL_GAP    (GAP),
    .TIMEOUT     (TMO)
  ) dut (
    .mgmt_clk              (mgmt_clk),
    .mgmt_rst              (mgmt_rst),
    .i_start               (i_start),
    .o_wr_addr             (o_wr_addr),
    .o_wrdata              (o_wrdata),
    .o_wren                (o_wren),
    .o_rden                (o_rden),
    .i_master_waitreq      (waitreq),
    .i_master_readdatavalid(rvalid),
    .i_master_readdata     (rdata),
    .o_busy                (o_busy),
    .o_test_done           (o_test_done),
    .o_test_pass           (o_test_pass),
    .o_l2f_sts             (o_l2f_sts),
    .o_f2l_sts             (o_f2l_sts),
    .o_err_code            (o_err_code)
  );

  initial forever #5 mgmt_clk = ~mgmt_clk;

  int checks = 0;
  int errors = 0;

  // responder configuration
  int          wait_n    = 0;
  int          rd_lat    = 2;
  int          link_left = 0;
  int          link_fail = 0;
  bit          link_never = 1'b0;
  bit          stray_en  = 1'b0;
  logic [31:0] l2f_word  = 32'h0B;
  logic [31:0] f2l_word  = 32'h0B;
  logic [31:0] dout_mem [8];
  logic [31:0] din_mem  [8];

  // transaction log
  int          cyc = 0;
  logic [31:0] wr_a_q [$];
  logic [31:0] wr_d_q [$];
  int          wr_c_q [$];
  int          link_req_q [$];
  int          link_val_q [$];

  logic [31:0] exp_wa [7] = '{32'h5000_2000, 32'h5000_2004, 32'h5000_2008, 32'h5000_3000,
                              32'h5000_3000, 32'h5000_1000, 32'h5000_1008};
  logic [31:0] exp_wd [7] = '{32'h0000_000C, 32'h0000_0020, 32'h0000_1770, 32'h0000_0001,
                              32'h0000_0000, 32'h0000_0FF5, 32'h0000_0FF5};

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {o_wr_addr, o_wrdata, o_wren, o_rden, o_busy, o_test_done, o_test_pass,
              o_l2f_sts, o_f2l_sts, o_err_code}, 256'd0);
  endtask

  // AVMM slave: stalls each request wait_n edges, answers reads rd_lat edges after acceptance
  initial begin : responder
    int          age;
    int          lat_cnt;
    bit          pend;
    bit          prev_req;
    bit          link_pend;
    logic [31:0] first_a, first_d, resp;
    age = 0; lat_cnt = 0; pend = 1'b0; prev_req = 1'b0; link_pend = 1'b0;
    first_a = 32'd0; first_d = 32'd0; resp = 32'd0;
    forever begin
      @(negedge mgmt_clk);
      cyc++;
      rvalid = 1'b0;
      if (mgmt_rst) begin
        pend = 1'b0; prev_req = 1'b0; age = 0;
        waitreq = (wait_n != 0);
      end else begin
        if (pend) begin
          lat_cnt--;
          if (lat_cnt == 0) begin
            rvalid = 1'b1;
            rdata  = resp;
            pend   = 1'b0;
            if (link_pend) link_val_q.push_back(cyc);
          end
        end else if (stray_en && !o_rden && ($urandom_range(0, 5) == 0)) begin
          rvalid = 1'b1;
          rdata  = $urandom;
        end
        if (o_wren || o_rden) begin
          if (!prev_req) begin
            first_a = o_wr_addr;
            first_d = o_wrdata;
            if (o_rden && o_wr_addr == LINK_ADDR) link_req_q.push_back(cyc);
          end
          if (waitreq) begin
            age++;
            if (age > wait_n) waitreq = 1'b0;
          end
          if (!waitreq) begin
            if (wait_n != 0) begin
              chk("hold_addr", o_wr_addr, first_a);
              chk("hold_data", o_wrdata, first_d);
            end
            if (o_wren) begin
              wr_a_q.push_back(o_wr_addr);
              wr_d_q.push_back(o_wrdata);
              wr_c_q.push_back(cyc);
            end else begin
              link_pend = (o_wr_addr == LINK_ADDR);
              if (link_pend) begin
                if (link_never || link_left > 0) begin
                  resp = 32'h7;
                  if (link_left > 0) link_left--;
                end else begin
                  resp = 32'hF;
                end
              end else if (o_wr_addr == 32'h5000_1004) resp = l2f_word;
              else if (o_wr_addr == 32'h5000_100C) resp = f2l_word;
              else if (o_wr_addr[31:8] == 24'h500041) resp = dout_mem[o_wr_addr[4:2]];
              else if (o_wr_addr[31:8] == 24'h500043) resp = din_mem[o_wr_addr[4:2]];
              else resp = 32'hDEAD_BEEF;
              pend    = 1'b1;
              lat_cnt = rd_lat;
            end
          end
        end else begin
          waitreq = (wait_n != 0);
          age = 0;
        end
        prev_req = o_wren || o_rden;
      end
    end
  end

  task automatic setup(input int wn, input int lat, input int lf, input bit never,
                       input logic [31:0] l2f, input logic [31:0] f2l,
                       input bit corrupt, input bit stray);
    wait_n = wn; rd_lat = lat; link_fail = lf; link_left = lf; link_never = never;
    l2f_word = l2f; f2l_word = f2l; stray_en = stray;
    for (int k = 0; k < 8; k++) begin
      dout_mem[k] = $urandom;
      din_mem[k]  = dout_mem[k];
    end
    if (corrupt) din_mem[3] = dout_mem[3] ^ (32'd1 << $urandom_range(0, 31));
  endtask

  task automatic do_reset();
    @(negedge mgmt_clk);
    mgmt_rst = 1'b1;
    i_start  = 1'b0;
    @(negedge mgmt_clk);
    chk_zero("rst_outputs");
    mgmt_rst = 1'b0;
    wr_a_q.delete(); wr_d_q.delete(); wr_c_q.delete();
    link_req_q.delete(); link_val_q.delete();
  endtask

  task automatic run_to_done();
    @(negedge mgmt_clk);
    i_start = 1'b1;
    @(negedge mgmt_clk);
    i_start = 1'b0;
    for (int i = 0; i < 20000 && o_test_done !== 1'b1; i++) @(negedge mgmt_clk);
    chk("done_wait", o_test_done, 1'b1);
  endtask

  task automatic check_result(input string nm);
    logic [2:0] e_l2f, e_f2l;
    bit         same;
    bit         e_pass;
    int         n_wr;
    n_wr = link_never ? 5 : 7;
    chk({nm, "_busy"}, o_busy, 1'b0);
    chk({nm, "_wr_count"}, wr_a_q.size(), n_wr);
    for (int i = 0; i < n_wr && i < wr_a_q.size(); i++) begin
      chk($sformatf("%s_wr%0d_addr", nm, i), wr_a_q[i], exp_wa[i]);
      chk($sformatf("%s_wr%0d_data", nm, i), wr_d_q[i], exp_wd[i]);
    end
    if (wr_c_q.size() >= 5) chk({nm, "_rst_hold"}, (wr_c_q[4] - wr_c_q[3]) > int'(HOLD), 1'b1);
    if (link_never) begin
      chk({nm, "_err_code"}, o_err_code, 4'd7);
      chk({nm, "_pass"}, o_test_pass, 1'b0);
    end else begin
      e_l2f = {l2f_word[3], l2f_word[1], l2f_word[0]};
      e_f2l = {f2l_word[3], f2l_word[1], f2l_word[0]};
      same  = 1'b1;
      for (int k = 0; k < 8; k++) if (dout_mem[k] != din_mem[k]) same = 1'b0;
      e_pass = (e_l2f == 3'b111) && (e_f2l == 3'b111) && same;
      chk({nm, "_err_code"}, o_err_code, 4'd0);
      chk({nm, "_l2f_sts"}, o_l2f_sts, e_l2f);
      chk({nm, "_f2l_sts"}, o_f2l_sts, e_f2l);
      chk({nm, "_pass"}, o_test_pass, e_pass);
      chk({nm, "_link_reads"}, link_req_q.size(), link_fail + 1);
      for (int i = 1; i < link_req_q.size() && i <= link_val_q.size(); i++)
        chk({nm, "_poll_gap"}, (link_req_q[i] - link_val_q[i-1] - 1) >= int'(GAP), 1'b1);
    end
  endtask

  initial begin : main
    int n;
    repeat (3) @(negedge mgmt_clk);

    setup(0, 2, 0, 1'b0, 32'h0B, 32'h0B, 1'b0, 1'b0);
    do_reset(); run_to_done(); check_result("ideal");
    n = wr_a_q.size();
    @(negedge mgmt_clk); i_start = 1'b1;
    @(negedge mgmt_clk); i_start = 1'b0;
    repeat (30) @(negedge mgmt_clk);
    chk("done_ignores_start", wr_a_q.size(), n);
    chk("done_sticky", {o_test_done, o_test_pass, o_busy}, 3'b110);

    setup(5, 2, 0, 1'b0, 32'h0B, 32'h0B, 1'b0, 1'b0);
    do_reset(); run_to_done(); check_result("waitreq5");

    setup(0, 2, 3, 1'b0, 32'h0B, 32'h0B, 1'b0, 1'b0);
    do_reset(); run_to_done(); check_result("link_retry");

    setup(0, 2, 0, 1'b0, 32'h0B, 32'h0B, 1'b1, 1'b0);
    do_reset(); run_to_done(); check_result("din_mismatch");

    setup(0, 2, 0, 1'b0, 32'h0A, 32'h0B, 1'b0, 1'b0);
    do_reset(); run_to_done(); check_result("l2f_bad");

    setup(0, 2, 0, 1'b1, 32'h0B, 32'h0B, 1'b0, 1'b0);
    do_reset(); run_to_done(); check_result("link_timeout");

    // reset in the middle of POLL_LINK
    setup(0, 2, 0, 1'b1, 32'h0B, 32'h0B, 1'b0, 1'b0);
    do_reset();
    @(negedge mgmt_clk); i_start = 1'b1;
    @(negedge mgmt_clk); i_start = 1'b0;
    for (int i = 0; i < 2000 && link_req_q.size() < 2; i++) @(negedge mgmt_clk);
    chk("mid_busy", o_busy, 1'b1);
    mgmt_rst = 1'b1;
    @(negedge mgmt_clk);
    chk_zero("mid_rst_outputs");
    mgmt_rst = 1'b0;
    repeat (10) @(negedge mgmt_clk);
    chk("mid_rst_idle", {o_busy, o_wren, o_rden}, 3'b000);

    // start coincident with reset is ignored
    @(negedge mgmt_clk); mgmt_rst = 1'b1; i_start = 1'b1;
    @(negedge mgmt_clk); mgmt_rst = 1'b0; i_start = 1'b0;
    wr_a_q.delete();
    repeat (10) @(negedge mgmt_clk);
    chk("rst_start_busy", o_busy, 1'b0);
    chk("rst_start_writes", wr_a_q.size(), 0);

    for (int r = 0; r < 6; r++) begin
      setup($urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 3), 1'b0,
            32'($urandom) | 32'h8, 32'($urandom) | 32'h8, 1'($urandom_range(0, 1)), 1'b1);
      do_reset(); run_to_done(); check_result($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
